// File: rtl/spi_master_cfg.sv
//------------------------------------------------------------------------------
// spi_master_cfg
//
// Parametrised SPI master. Each accepted send pulse moves one DATA_W-bit word
// out on MOSI while the same number of bits is collected from MISO. SPI mode
// (cpol/cpha), bit order and target slave select are chosen per transfer and
// latched when the request is accepted, so those inputs may change freely
// while a transfer is running.
//
// Transfer sequence (one state per phase):
//   IDLE  -> SETUP (HALF_DIV cycles, SS low, first bit on MOSI for cpha=0)
//         -> SHIFT (2*DATA_W SCLK edges, one every HALF_DIV cycles, followed
//                   by one final half-period at the idle level)
//         -> HOLD  (HALF_DIV cycles, SCLK idle, SS still low)
//         -> DONE  (1 cycle, SS released, done pulse, new data_out)
//         -> IDLE
// A request accepted in cycle 0 produces done in cycle
// (2*DATA_W+2)*HALF_DIV+1.
//
// Parameters
//   DATA_W    bits per transfer (>= 2)
//   HALF_DIV  clk cycles per SCLK half-period (>= 2)
//   NSS       number of active-low slave selects (1..8)
//
// Ports
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset; aborts any transfer
//   send       start request, only looked at in IDLE
//   data_in    TX word, latched on accept
//   cpol       SCLK idle level, latched on accept
//   cpha       0: sample on leading edge, 1: sample on trailing edge
//   lsb_first  0: MSB first, 1: LSB first (both directions)
//   ss_sel     slave index; a request with ss_sel >= NSS is dropped
//   data_out   last received word, updated in the DONE cycle
//   done       one-cycle completion pulse
//   busy       high from the cycle after accept through the DONE cycle
//   MISO       serial data from the slave
//   MOSI       serial data to the slave
//   SCLK       serial clock
//   SS         active-low slave selects, at most one low at a time
//------------------------------------------------------------------------------
module spi_master_cfg #(
   parameter int  DATA_W   = 16,
   parameter int  HALF_DIV = 8,
   parameter int  NSS      = 1,
   localparam int SEL_W    = (NSS > 1) ? $clog2(NSS) : 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              send,
   input  logic [DATA_W-1:0] data_in,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [SEL_W-1:0]  ss_sel,
   output logic [DATA_W-1:0] data_out,
   output logic              done,
   output logic              busy,
   input  logic              MISO,
   output logic              MOSI,
   output logic              SCLK,
   output logic [NSS-1:0]    SS
);

   localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST        = DIV_W'(HALF_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_TOTAL      = EDGE_W'(2 * DATA_W);
   localparam logic [EDGE_W-1:0] EDGE_PENULTIMATE = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   // Latched transfer configuration
   logic              cpol_q;
   logic              cpha_q;
   logic              lsb_q;
   logic [SEL_W-1:0]  sel_q;

   // Timing and shift datapath
   logic [DIV_W-1:0]  div_q;
   logic [EDGE_W-1:0] edge_q;    // SCLK edges generated so far in this transfer
   logic [DATA_W-1:0] tx_q;      // bits still to be driven, next one at the head
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] dout_q;
   logic              sclk_q;
   logic              mosi_q;

   // Decode
   logic accept;
   logic half_end;
   logic last_edge;
   logic leading;                // the next SCLK edge leaves the idle level
   logic sample_now;
   logic drive_now;

   //---------------------------------------------------------------------------
   // Bit-order helpers: the head of a word is the bit that goes out next.
   //---------------------------------------------------------------------------
   function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   // New bits enter at the far end so the first bit received ends up at the
   // position it was sent from (bit DATA_W-1 for MSB first, bit 0 for LSB first).
   function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w,
                                                  input logic lsb, input logic b);
      return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   assign accept    = send && (int'(ss_sel) < NSS);
   assign half_end  = (div_q == DIV_LAST);
   assign last_edge = (edge_q == EDGE_TOTAL);
   assign leading   = ~edge_q[0];

   // cpha=0: sample on leading edges, drive on trailing edges except the last.
   // cpha=1: drive on leading edges, sample on trailing edges.
   assign sample_now = cpha_q ? ~leading : leading;
   assign drive_now  = cpha_q ? leading  : (~leading && (edge_q != EDGE_PENULTIMATE));

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   // NOTE: the default assignment at the top gives state_d a value on every
   // path, so no latch is inferred when a branch leaves it untouched.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept)                state_d = ST_SETUP;
         ST_SETUP: if (half_end)              state_d = ST_SHIFT;
         ST_SHIFT: if (half_end && last_edge) state_d = ST_HOLD;
         ST_HOLD:  if (half_end)              state_d = ST_DONE;
         ST_DONE:                             state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs decoded from state
   //---------------------------------------------------------------------------
   always_comb begin
      done = 1'b0;
      busy = 1'b1;
      SS   = '1;
      unique case (state_q)
         ST_IDLE: busy = 1'b0;
         ST_DONE: done = 1'b1;
         default: begin
            for (int i = 0; i < NSS; i++) begin
               if (sel_q == SEL_W'(i)) SS[i] = 1'b0;
            end
         end
      endcase
   end

   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign data_out = dout_q;

   //---------------------------------------------------------------------------
   // Datapath: divider, edge counter, shift registers, SCLK and MOSI.
   //---------------------------------------------------------------------------
   // NOTE: the shift registers are ordinary flops, not a memory array, so they
   // take the asynchronous reset like everything else; a reset mid-transfer
   // discards any partially received word.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         lsb_q  <= 1'b0;
         sel_q  <= '0;
         div_q  <= '0;
         edge_q <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
         dout_q <= '0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // SCLK follows the requested idle level so it is already
               // correct when SS drops.
               sclk_q <= cpol;
               div_q  <= '0;
               edge_q <= '0;
               if (accept) begin
                  cpol_q <= cpol;
                  cpha_q <= cpha;
                  lsb_q  <= lsb_first;
                  sel_q  <= ss_sel;
                  rx_q   <= '0;
                  if (!cpha) begin
                     // cpha=0 presents the first bit before the first edge.
                     mosi_q <= head_bit(data_in, lsb_first);
                     tx_q   <= drop_head(data_in, lsb_first);
                  end else begin
                     mosi_q <= 1'b0;
                     tx_q   <= data_in;
                  end
               end
            end

            ST_SETUP, ST_SHIFT: begin
               if (half_end) begin
                  div_q <= '0;
                  // After the final edge SHIFT runs one more half-period with
                  // SCLK parked, then hands over to HOLD.
                  if (!last_edge) begin
                     sclk_q <= ~sclk_q;
                     edge_q <= edge_q + EDGE_W'(1);
                     if (sample_now) rx_q <= push_bit(rx_q, lsb_q, MISO);
                     if (drive_now) begin
                        mosi_q <= head_bit(tx_q, lsb_q);
                        tx_q   <= drop_head(tx_q, lsb_q);
                     end
                  end
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            ST_HOLD: begin
               sclk_q <= cpol_q;
               if (half_end) begin
                  div_q  <= '0;
                  dout_q <= rx_q;
                  mosi_q <= 1'b0;
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            ST_DONE: begin
               div_q <= '0;
            end

            default: begin
               div_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_cfg.sv
//------------------------------------------------------------------------------
// tb_spi_master_cfg
//
// Two masters share one stimulus bus: u_dut_a with default parameters
// (16 bits, HALF_DIV=8, one slave select) and u_dut_b with DATA_W=8,
// HALF_DIV=2, NSS=4. dsel picks which one receives send and which one the
// slave model listens to.
//
// The slave model works on SPI wire events only: it watches SS and SCLK edges,
// shifts its own word out on MISO on its drive edges, collects MOSI on its
// sample edges, and flags MOSI changing anywhere but a drive edge. The transfer
// task compares the collected word, the latency and the handshake outputs
// against values computed from the transfer arguments.
//------------------------------------------------------------------------------
module tb_spi_master_cfg;

   logic        clk = 1'b0;
   logic        nrst;
   logic        send;
   logic        cpol;
   logic        cpha;
   logic        lsb_first;
   logic [15:0] data_in;
   logic [2:0]  ss_sel;
   logic        dsel;
   logic        send_a, send_b;

   logic [15:0] dout_a;
   logic        done_a, busy_a, mosi_a, sclk_a;
   logic [0:0]  ss_a;
   logic [7:0]  dout_b;
   logic        done_b, busy_b, mosi_b, sclk_b;
   logic [3:0]  ss_b;

   logic        miso_line;
   logic        slave_miso;
   logic        loop_en;

   // Outputs of the selected master, widened to common sizes
   logic        obs_sclk, obs_mosi, obs_done, obs_busy;
   logic [7:0]  obs_ss;
   logic [15:0] obs_dout;

   int n_tests = 0;
   int n_fail  = 0;

   // Slave model configuration
   int          m_dw   = 16;
   logic        m_cpha = 1'b0;
   logic        m_lsb  = 1'b0;
   logic [15:0] m_miso = '0;

   // Slave model state
   logic        s_act       = 1'b0;
   logic        s_prev_sclk = 1'b0;
   logic        s_prev_mosi = 1'b0;
   int          s_edges     = 0;
   int          s_tx_i      = 0;
   int          s_rx_i      = 0;
   logic [15:0] s_rx        = '0;
   int          s_viol      = 0;
   logic        act_now, sclk_chg, drv_edge, lead;

   always #5 clk = ~clk;

   assign send_a    = send & ~dsel;
   assign send_b    = send & dsel;
   assign miso_line = loop_en ? obs_mosi : slave_miso;

   spi_master_cfg u_dut_a (
      .clk       (clk),
      .nrst      (nrst),
      .send      (send_a),
      .data_in   (data_in),
      .cpol      (cpol),
      .cpha      (cpha),
      .lsb_first (lsb_first),
      .ss_sel    (ss_sel[0:0]),
      .data_out  (dout_a),
      .done      (done_a),
      .busy      (busy_a),
      .MISO      (miso_line),
      .MOSI      (mosi_a),
      .SCLK      (sclk_a),
      .SS        (ss_a)
   );

   spi_master_cfg #(.DATA_W(8), .HALF_DIV(2), .NSS(4)) u_dut_b (
      .clk       (clk),
      .nrst      (nrst),
      .send      (send_b),
      .data_in   (data_in[7:0]),
      .cpol      (cpol),
      .cpha      (cpha),
      .lsb_first (lsb_first),
      .ss_sel    (ss_sel[1:0]),
      .data_out  (dout_b),
      .done      (done_b),
      .busy      (busy_b),
      .MISO      (miso_line),
      .MOSI      (mosi_b),
      .SCLK      (sclk_b),
      .SS        (ss_b)
   );

   always_comb begin
      if (dsel) begin
         obs_sclk = sclk_b;
         obs_mosi = mosi_b;
         obs_ss   = {4'hf, ss_b};
         obs_done = done_b;
         obs_busy = busy_b;
         obs_dout = {8'h00, dout_b};
      end else begin
         obs_sclk = sclk_a;
         obs_mosi = mosi_a;
         obs_ss   = {7'h7f, ss_a};
         obs_done = done_a;
         obs_busy = busy_a;
         obs_dout = dout_a;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wire position of the i-th bit on the line
   function automatic int bit_pos(input int i);
      return m_lsb ? i : (m_dw - 1 - i);
   endfunction

   //---------------------------------------------------------------------------
   // SPI slave model, evaluated half a clock after every DUT update.
   //---------------------------------------------------------------------------
   always @(negedge clk) begin
      act_now  = (obs_ss != 8'hff);
      sclk_chg = (obs_sclk != s_prev_sclk);
      drv_edge = 1'b0;
      if (act_now && !s_act) begin
         s_edges = 0;
         s_tx_i  = 0;
         s_rx_i  = 0;
         s_rx    = '0;
         s_viol  = 0;
         if (!m_cpha) begin
            slave_miso = m_miso[bit_pos(0)];
            s_tx_i     = 1;
         end
      end else if (act_now && sclk_chg) begin
         s_edges++;
         lead = (s_edges % 2) == 1;
         if (m_cpha ? !lead : lead) begin
            if (s_rx_i < m_dw) s_rx[bit_pos(s_rx_i)] = obs_mosi;
            s_rx_i++;
         end
         if (m_cpha ? lead : !lead) begin
            drv_edge = 1'b1;
            if (s_tx_i < m_dw) begin
               slave_miso = m_miso[bit_pos(s_tx_i)];
               s_tx_i++;
            end
         end
      end
      if (act_now && s_act && (obs_mosi != s_prev_mosi) && !drv_edge) s_viol++;
      s_act       = act_now;
      s_prev_sclk = obs_sclk;
      s_prev_mosi = obs_mosi;
   end

   //---------------------------------------------------------------------------
   // One transfer. Called at a negedge; returns at the negedge of the first
   // IDLE cycle after done, so the next call makes a back-to-back request.
   //   repulse : cycle in which a second send with 0xFFFF is attempted (0 = off)
   //   poke    : attempt a send during the DONE cycle
   //   rst_at  : cycle in which nrst is pulled low to abort (0 = off)
   //---------------------------------------------------------------------------
   task automatic xfer(input logic d, input logic [15:0] din, input logic [15:0] mw,
                       input logic pol, input logic pha, input logic lsb,
                       input logic [2:0] sel, input logic loop,
                       input int repulse, input logic poke, input int rst_at);
      int          dw, h, lat, done_cnt, done_at;
      logic [15:0] mask, exp_out;
      logic        busy_bad, ss_bad, first_bit, aborted;

      dw       = d ? 8 : 16;
      h        = d ? 2 : 8;
      lat      = (2 * dw + 2) * h + 1;
      mask     = d ? 16'h00ff : 16'hffff;
      exp_out  = loop ? (din & mask) : (mw & mask);
      first_bit = pha ? 1'b0 : (lsb ? din[0] : din[dw-1]);
      done_cnt = 0;
      done_at  = -1;
      busy_bad = 1'b0;
      ss_bad   = 1'b0;
      aborted  = 1'b0;

      dsel    = d;
      loop_en = loop;
      m_dw    = dw;
      m_cpha  = pha;
      m_lsb   = lsb;
      m_miso  = mw & mask;

      data_in   = din;
      cpol      = pol;
      cpha      = pha;
      lsb_first = lsb;
      ss_sel    = sel;
      send      = 1'b1;

      for (int cyc = 1; cyc <= lat + 1; cyc++) begin
         @(negedge clk);
         // Latched inputs are scrambled to show they no longer matter.
         send      = 1'b0;
         cpol      = 1'($urandom);
         cpha      = 1'($urandom);
         lsb_first = 1'($urandom);
         data_in   = 16'($urandom);
         ss_sel    = 3'($urandom);
         if (cyc == rst_at) begin
            nrst = 1'b0;
            #1;
            check("rst_ss",   32'(obs_ss),   32'(8'hff));
            check("rst_sclk", 32'(obs_sclk), 32'(0));
            check("rst_busy", 32'(obs_busy), 32'(0));
            check("rst_dout", 32'(obs_dout), 32'(0));
            repeat (3) begin
               @(negedge clk);
               if (obs_done) done_cnt++;
            end
            check("rst_no_done", 32'(done_cnt), 32'(0));
            nrst    = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (cyc == repulse) begin
            send    = 1'b1;
            data_in = 16'hffff;
            ss_sel  = sel;
         end
         if (poke && cyc == lat) begin
            send   = 1'b1;
            ss_sel = sel;
         end
         if (cyc == 1) begin
            check("setup_sclk", 32'(obs_sclk), 32'(pol));
            check("setup_mosi", 32'(obs_mosi), 32'(first_bit));
         end
         if (obs_done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = cyc;
               check("dout", 32'(obs_dout), 32'(exp_out));
            end
         end
         if (cyc <= lat && !obs_busy) busy_bad = 1'b1;
         if (cyc < lat && obs_ss != ~(8'h01 << sel)) ss_bad = 1'b1;
         if (cyc >= lat && obs_ss != 8'hff) ss_bad = 1'b1;
      end
      if (aborted) return;

      check("done_count",  32'(done_cnt),  32'(1));
      check("latency",     32'(done_at),   32'(lat));
      check("busy_span",   32'(busy_bad),  32'(0));
      check("ss_select",   32'(ss_bad),    32'(0));
      check("busy_after",  32'(obs_busy),  32'(0));
      check("dout_held",   32'(obs_dout),  32'(exp_out));
      check("idle_sclk",   32'(obs_sclk),  32'(pol));
      check("idle_mosi",   32'(obs_mosi),  32'(0));
      check("mosi_word",   32'(s_rx),      32'(din & mask));
      check("sclk_edges",  32'(s_edges),   32'(2 * dw));
      check("mosi_timing", 32'(s_viol),    32'(0));
   endtask

   // A request naming a nonexistent slave must leave the master idle.
   task automatic send_ignored(input logic d, input logic [2:0] sel);
      logic bad;
      bad     = 1'b0;
      dsel    = d;
      ss_sel  = sel;
      data_in = 16'($urandom);
      send    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         send = 1'b0;
         if (obs_busy || obs_done || obs_ss != 8'hff) bad = 1'b1;
      end
      check("bad_sel_ignored", 32'(bad), 32'(0));
   endtask

   initial begin
      nrst       = 1'b0;
      send       = 1'b0;
      cpol       = 1'b0;
      cpha       = 1'b0;
      lsb_first  = 1'b0;
      data_in    = '0;
      ss_sel     = '0;
      dsel       = 1'b0;
      loop_en    = 1'b0;
      slave_miso = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("reset_ss_a",   32'(obs_ss),   32'(8'hff));
      check("reset_sclk_a", 32'(obs_sclk), 32'(0));
      check("reset_mosi_a", 32'(obs_mosi), 32'(0));
      check("reset_dout_a", 32'(obs_dout), 32'(0));
      check("reset_done_a", 32'(obs_done), 32'(0));
      check("reset_busy_a", 32'(obs_busy), 32'(0));
      dsel = 1'b1;
      #1;
      check("reset_ss_b",   32'(obs_ss),   32'(8'hff));
      check("reset_busy_b", 32'(obs_busy), 32'(0));
      @(negedge clk);
      nrst = 1'b1;
      dsel = 1'b0;
      @(negedge clk);

      // Mode 0, MSB first, 273-cycle latency
      xfer(1'b0, 16'hAA33, 16'hAAAA, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0, 0);
      // Mode 3, back-to-back with the previous transfer
      xfer(1'b0, 16'h8888, 16'h0AA8, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 0, 1'b0, 0);
      // LSB first with MISO looped back to MOSI
      xfer(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 0, 1'b0, 0);
      // Second send mid-transfer and a send in the DONE cycle are both dropped
      xfer(1'b0, 16'h5A3C, 16'hC3A5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 50, 1'b1, 0);
      // Only one slave select exists on u_dut_a
      send_ignored(1'b0, 3'd1);
      // Abort with nrst, then a normal transfer afterwards
      xfer(1'b0, 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0, 100);
      xfer(1'b0, 16'hBEEF, 16'h7E81, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 0, 1'b0, 0);

      // Small instance: only SS[2] low, done in cycle (2*8+2)*2+1
      xfer(1'b1, 16'h00C5, 16'h005A, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 0, 1'b0, 0);
      for (int k = 0; k < 6; k++) begin
         xfer(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
              0, 1'b0, 0);
      end
      for (int k = 0; k < 4; k++) begin
         xfer(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 3'd0, 1'b0, 0, 1'($urandom), 0);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
